ddr3_axi_burst_split: RTL

Second-generation AXI4 request front-end for the DDR3 memory controller. Accepts AXI4 INCR read and write address requests and arbitrates between them onto one memory-command port. Splits each AXI burst into aligned MEM_BURST_LEN-beat memory commands with monotonically increasing order tags. On the read return path it trims leading and trailing padding beats and regenerates RLAST/RID. It issues write responses once all fragments of a write have been accepted. Write data is carried by the existing write datapath; this block handles commands and responses only.

---
 rtl/ddr3_axi_burst_split_pkg.sv | 13 +
 rtl/ddr3_axi_burst_split_if.sv | 45 ++++
 rtl/ddr3_axi_burst_split_sync_fifo.sv | 47 ++++
 rtl/ddr3_axi_burst_split.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ddr3_axi_burst_split_pkg.sv
// Shared constants, FSM encoding and the context-record width helper for the
// AXI burst splitter.
package ddr3_axi_burst_split_pkg;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  // {id, off, len, nfrag}
  function automatic int ctx_width(input int id_w, input int bl);
    return id_w + $clog2(bl) + 8 + 9;
  endfunction
endpackage

// File: rtl/ddr3_axi_burst_split_if.sv
// AXI command/response side plus memory command/read-data side of the splitter.
interface ddr3_axi_burst_split_if #(
  parameter int ADDRS        = 32,
  parameter int WIDTH        = 32,
  parameter int AXI_ID_WIDTH = 4,
  parameter int MEM_ID_WIDTH = 4
);
  logic                    axi_awvalid_i, axi_awready_o;
  logic [ADDRS-1:0]        axi_awaddr_i;
  logic [AXI_ID_WIDTH-1:0] axi_awid_i;
  logic [7:0]              axi_awlen_i;
  logic                    axi_bvalid_o, axi_bready_i;
  logic [AXI_ID_WIDTH-1:0] axi_bid_o;
  logic [1:0]              axi_bresp_o;
  logic                    axi_arvalid_i, axi_arready_o;
  logic [ADDRS-1:0]        axi_araddr_i;
  logic [AXI_ID_WIDTH-1:0] axi_arid_i;
  logic [7:0]              axi_arlen_i;
  logic                    axi_rvalid_o, axi_rready_i, axi_rlast_o;
  logic [WIDTH-1:0]        axi_rdata_o;
  logic [AXI_ID_WIDTH-1:0] axi_rid_o;
  logic [1:0]              axi_rresp_o;
  logic                    mem_req_o, mem_ack_i, mem_wr_o, mem_lst_o;
  logic [MEM_ID_WIDTH-1:0] mem_tid_o;
  logic [ADDRS-1:0]        mem_adr_o;
  logic                    mem_valid_i, mem_ready_o, mem_rlast_i;
  logic [WIDTH-1:0]        mem_rdata_i;

  modport slave (
    input  axi_awvalid_i, axi_awaddr_i, axi_awid_i, axi_awlen_i, axi_bready_i,
           axi_arvalid_i, axi_araddr_i, axi_arid_i, axi_arlen_i, axi_rready_i,
           mem_ack_i, mem_valid_i, mem_rlast_i, mem_rdata_i,
    output axi_awready_o, axi_bvalid_o, axi_bid_o, axi_bresp_o, axi_arready_o,
           axi_rvalid_o, axi_rdata_o, axi_rid_o, axi_rresp_o, axi_rlast_o,
           mem_req_o, mem_wr_o, mem_lst_o, mem_tid_o, mem_adr_o, mem_ready_o
  );
  modport master (
    output axi_awvalid_i, axi_awaddr_i, axi_awid_i, axi_awlen_i, axi_bready_i,
           axi_arvalid_i, axi_araddr_i, axi_arid_i, axi_arlen_i, axi_rready_i,
           mem_ack_i, mem_valid_i, mem_rlast_i, mem_rdata_i,
    input  axi_awready_o, axi_bvalid_o, axi_bid_o, axi_bresp_o, axi_arready_o,
           axi_rvalid_o, axi_rdata_o, axi_rid_o, axi_rresp_o, axi_rlast_o,
           mem_req_o, mem_wr_o, mem_lst_o, mem_tid_o, mem_adr_o, mem_ready_o
  );
endinterface

// File: rtl/ddr3_axi_burst_split_sync_fifo.sv
// Show-ahead synchronous FIFO (DEPTH must be a power of two). A push while
// full is taken when a pop happens in the same cycle.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign dout    = mem[rp];

  always_ff @(posedge clock) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/ddr3_axi_burst_split.sv
// AXI4 INCR read/write command splitter into aligned memory-burst fragments,
// with read-return trimming and write-response queueing.
// Define DDR3_AXI_SPLIT_RR_EN for round-robin AW/AR arbitration.
module ddr3_axi_burst_split
  import ddr3_axi_burst_split_pkg::*;
#(
  parameter int ADDRS          = 32,
  parameter int WIDTH          = 32,
  parameter int MASKS          = WIDTH / 8,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_ID_WIDTH   = 4,
  parameter int MEM_BURST_LEN  = 4,
  parameter int CTX_FIFO_DEPTH = 16
) (
  input logic                  clock,
  input logic                  reset,
  ddr3_axi_burst_split_if.slave bus
);
  localparam int BEAT_LSB = $clog2(MASKS);
  localparam int OFF_W    = $clog2(MEM_BURST_LEN);
  localparam int FRAG_LSB = BEAT_LSB + OFF_W;
  localparam int CTX_W    = ctx_width(AXI_ID_WIDTH, MEM_BURST_LEN);
  localparam logic [ADDRS-1:0] FRAG_STEP = ADDRS'(MEM_BURST_LEN * MASKS);

  state_t                  state;
  logic                    req_q, wr_q, lst_q;
  logic [ADDRS-1:0]        adr_q;
  logic [MEM_ID_WIDTH-1:0] tag_q;
  logic [AXI_ID_WIDTH-1:0] id_q;
  logic [8:0]              frag_cnt;

  logic                    ctx_full, ctx_empty, ctx_pop, b_full, b_empty, b_push;
  logic                    ar_ok, aw_ok, sel_ar, sel_aw;
  logic [ADDRS-1:0]        sel_adr;
  logic [7:0]              sel_len;
  logic [AXI_ID_WIDTH-1:0] sel_id;
  logic [OFF_W-1:0]        sel_off;
  logic [9:0]              span;
  logic [8:0]              nfrag;
  logic [CTX_W-1:0]        ctx_dout;
  logic [AXI_ID_WIDTH-1:0] b_dout;

  assign ar_ok = bus.axi_arvalid_i && !ctx_full;
  assign aw_ok = bus.axi_awvalid_i && !b_full;

`ifdef DDR3_AXI_SPLIT_RR_EN
  logic last_wr;
  always_ff @(posedge clock)
    if (reset)                              last_wr <= 1'b1;
    else if (state == IDLE && (sel_ar || sel_aw)) last_wr <= sel_aw;
  assign sel_ar = ar_ok && (!aw_ok || last_wr);
`else
  assign sel_ar = ar_ok;
`endif
  assign sel_aw = aw_ok && !sel_ar;

  assign bus.axi_arready_o = (state == IDLE) && sel_ar;
  assign bus.axi_awready_o = (state == IDLE) && sel_aw;

  assign sel_adr = sel_ar ? bus.axi_araddr_i : bus.axi_awaddr_i;
  assign sel_len = sel_ar ? bus.axi_arlen_i  : bus.axi_awlen_i;
  assign sel_id  = sel_ar ? bus.axi_arid_i   : bus.axi_awid_i;
  assign sel_off = sel_adr[FRAG_LSB-1:BEAT_LSB];
  // ceil((off+len+1)/BL); 10 bits holds the worst case before the shift
  assign span    = 10'(sel_off) + 10'(sel_len) + 10'd1 + 10'(MEM_BURST_LEN - 1);
  assign nfrag   = 9'(span >> OFF_W);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      lst_q    <= 1'b0;
      adr_q    <= '0;
      tag_q    <= '0;
      id_q     <= '0;
      frag_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (sel_ar || sel_aw) begin
          state    <= ISSUE;
          req_q    <= 1'b1;
          wr_q     <= sel_aw;
          adr_q    <= {sel_adr[ADDRS-1:FRAG_LSB], FRAG_LSB'(0)};
          frag_cnt <= nfrag;
          lst_q    <= (nfrag == 9'd1);
          id_q     <= sel_id;
        end
        ISSUE: if (bus.mem_ack_i) begin
          tag_q <= tag_q + MEM_ID_WIDTH'(1);
          if (lst_q) begin
            state <= IDLE;
            req_q <= 1'b0;
          end else begin
            adr_q    <= adr_q + FRAG_STEP;
            frag_cnt <= frag_cnt - 9'd1;
            lst_q    <= (frag_cnt == 9'd2);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req_o = req_q;
  assign bus.mem_wr_o  = wr_q;
  assign bus.mem_lst_o = lst_q;
  assign bus.mem_adr_o = adr_q;
  assign bus.mem_tid_o = tag_q;

  // B queue: slot reserved at AW accept time since only one burst is in flight
  assign b_push = (state == ISSUE) && bus.mem_ack_i && lst_q && wr_q;

  sync_fifo #(.W(AXI_ID_WIDTH), .DEPTH(CTX_FIFO_DEPTH)) u_bfifo (
    .clock(clock), .reset(reset),
    .push(b_push), .din(id_q),
    .pop(bus.axi_bvalid_o && bus.axi_bready_i),
    .dout(b_dout), .full(b_full), .empty(b_empty)
  );

  assign bus.axi_bvalid_o = !b_empty;
  assign bus.axi_bid_o    = b_empty ? '0 : b_dout;
  assign bus.axi_bresp_o  = RESP_OKAY;

  sync_fifo #(.W(CTX_W), .DEPTH(CTX_FIFO_DEPTH)) u_ctx (
    .clock(clock), .reset(reset),
    .push(bus.axi_arready_o), .din({sel_id, sel_off, sel_len, nfrag}),
    .pop(ctx_pop),
    .dout(ctx_dout), .full(ctx_full), .empty(ctx_empty)
  );

  logic [AXI_ID_WIDTH-1:0] c_id;
  logic [OFF_W-1:0]        c_off;
  logic [7:0]              c_len;
  logic [8:0]              c_nfrag, beat_c;
  logic [9:0]              rl_idx, end_idx;
  logic                    ctx_vld, pass, beat;

  assign {c_id, c_off, c_len, c_nfrag} = ctx_dout;
  assign ctx_vld = !ctx_empty;
  assign rl_idx  = 10'(c_off) + 10'(c_len);
  assign end_idx = (10'(c_nfrag) << OFF_W) - 10'd1;
  assign pass    = ctx_vld && (10'(beat_c) >= 10'(c_off)) && (10'(beat_c) <= rl_idx);

  // padding beats are always swallowed; data beats obey R backpressure
  assign bus.mem_ready_o  = ctx_vld && (pass ? bus.axi_rready_i : 1'b1);
  assign bus.axi_rvalid_o = pass && bus.mem_valid_i;
  assign bus.axi_rdata_o  = bus.axi_rvalid_o ? bus.mem_rdata_i : '0;
  assign bus.axi_rid_o    = ctx_vld ? c_id : '0;
  assign bus.axi_rlast_o  = bus.axi_rvalid_o && (10'(beat_c) == rl_idx);
  assign bus.axi_rresp_o  = RESP_OKAY;

  assign beat    = bus.mem_valid_i && bus.mem_ready_o;
  assign ctx_pop = beat && (10'(beat_c) == end_idx);

  always_ff @(posedge clock) begin
    if (reset)        beat_c <= '0;
    else if (ctx_pop) beat_c <= '0;
    else if (beat)    beat_c <= beat_c + 9'd1;
  end

  logic unused_ok;
  assign unused_ok = ^{bus.mem_rlast_i, sel_adr};
endmodule
